// File: rtl/apb_req_arbiter_if.sv
// Signal bundle between the two requesters, the APB arbiter and the APB slave.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [1:0]              req;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [2*STRB_WIDTH-1:0] req_strb;
  logic [1:0]              done;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [STRB_WIDTH-1:0]   pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    input  req, req_write, req_addr, req_wdata, req_strb,
    output done, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, req_strb,
    input  done, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB4 master: arbitrates, runs SETUP/ACCESS toward
// one slave, returns read data / error, and aborts slaves that stall too long.
module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic pclk,
  input  logic rst,
  apb_req_arbiter_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  logic                  write_a [2];
  logic [ADDR_WIDTH-1:0] addr_a  [2];
  logic [DATA_WIDTH-1:0] wdata_a [2];
  logic [STRB_WIDTH-1:0] strb_a  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign write_a[gi] = bus.req_write[gi];
    assign addr_a[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign strb_a[gi]  = bus.req_strb[gi*STRB_WIDTH +: STRB_WIDTH];
  end

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [1:0]            done_q, done_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  pick;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    done_d      = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    // Contested grant goes to whoever was not serviced last.
    pick = bus.req[1];
    if (bus.req == 2'b11) begin
      pick = ~last_gnt_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d    = pick;
          pwrite_d = write_a[pick];
          paddr_d  = addr_a[pick];
          pwdata_d = write_a[pick] ? wdata_a[pick] : '0;
          pstrb_d  = write_a[pick] ? strb_a[pick] : '0;
          psel_d   = 1'b1;
          penable_d = 1'b0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.pready || (cnt_q == CNT_LAST)) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          done_d[gnt_q]  = 1'b1;
          last_gnt_d     = gnt_q;
          rsp_err_d      = bus.pready ? bus.pslverr : 1'b1;
          rsp_rdata_d    = (bus.pready && !pwrite_q) ? bus.prdata : '0;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        // Dead cycle so a requester dropping req after done is not re-granted.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.done      = done_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: vector table, reset corner sequences, and random
// transfers checked against a transaction-level arbitration/response model.
module tb_apb_req_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  int   slv_wait = 0;
  int   acc_n = 0;

  always #5 pclk = ~pclk;

  apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.master)
  );

  // Slave: pready stays low for slv_wait ACCESS cycles, then rises.
  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      bus.pready = (acc_n >= slv_wait);
      acc_n++;
    end else begin
      acc_n = 0;
      bus.pready = 1'b0;
    end
  end

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    wr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [SW-1:0] s0, s1;
    int            wt;
    logic [DW-1:0] rd;
    logic          er;
    logic          drop;
    logic [1:0]    e_done;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [SW-1:0] e_strb;
    logic [DW-1:0] e_rd;
    logic          e_er;
    int            e_lat;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] req, logic [1:0] wr, logic [AW-1:0] a0, logic [AW-1:0] a1,
                               logic [DW-1:0] d0, logic [DW-1:0] d1, logic [SW-1:0] s0, logic [SW-1:0] s1,
                               int wt, logic [DW-1:0] rd, logic er,
                               logic [1:0] e_done, logic e_wr, logic [AW-1:0] e_addr, logic [DW-1:0] e_wd,
                               logic [SW-1:0] e_strb, logic [DW-1:0] e_rd, logic e_er, int e_lat);
    vec_t v;
    v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1;
    v.wt = wt; v.rd = rd; v.er = er; v.drop = 1'b0;
    v.e_done = e_done; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd; v.e_strb = e_strb;
    v.e_rd = e_rd; v.e_er = e_er; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.req       = v.req;
    bus.req_write = v.wr;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.d1, v.d0};
    bus.req_strb  = {v.s1, v.s0};
    slv_wait      = v.wt;
    bus.prdata    = v.rd;
    bus.pslverr   = v.er;
  endtask

  // One complete transfer starting with the DUT in IDLE; ends back in IDLE.
  task automatic run_xfer(input string tag, input vec_t v);
    int   cyc;
    logic got;
    logic stable;
    apply(v);
    step();
    cyc = 1;
    chk({tag, ".setup_psel"}, bus.psel, 1'b1);
    chk({tag, ".setup_penable"}, bus.penable, 1'b0);
    chk({tag, ".pwrite"}, bus.pwrite, v.e_wr);
    chk({tag, ".paddr"}, bus.paddr, v.e_addr);
    chk({tag, ".pwdata"}, bus.pwdata, v.e_wd);
    chk({tag, ".pstrb"}, bus.pstrb, v.e_strb);
    if (v.drop) begin
      bus.req       = 2'b00;
      bus.req_write = ~v.wr;
      bus.req_addr  = ~{v.a1, v.a0};
      bus.req_wdata = ~{v.d1, v.d0};
      bus.req_strb  = ~{v.s1, v.s0};
    end
    got = 1'b0;
    stable = 1'b1;
    while (!got && cyc < TIMEOUT + 10) begin
      step();
      cyc++;
      if (cyc == 2) chk({tag, ".access_penable"}, bus.penable, 1'b1);
      if (bus.paddr !== v.e_addr || bus.pwrite !== v.e_wr || bus.pstrb !== v.e_strb) stable = 1'b0;
      if (bus.done != 2'b00) got = 1'b1;
    end
    chk({tag, ".done_seen"}, got, 1'b1);
    chk({tag, ".latency"}, cyc, v.e_lat);
    chk({tag, ".done"}, bus.done, v.e_done);
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, v.e_rd);
    chk({tag, ".rsp_err"}, bus.rsp_err, v.e_er);
    chk({tag, ".exit_psel_penable"}, {bus.psel, bus.penable}, 2'b00);
    chk({tag, ".cmd_stable"}, stable, 1'b1);
    step();
    chk({tag, ".resp_clear"}, {bus.done, bus.rsp_err, bus.rsp_rdata}, '0);
  endtask

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, nvec=%0d", nvec);
    $fatal(1);
  end

  initial begin
    int   last;
    int   g;
    logic timed;
    vec_t v;

    tbl[0]  = mkv(2'b01, 2'b01, 12'h004, 12'h000, 32'hA5A5_1234, 32'h0, 4'hF, 4'h0, 0, 32'h0, 1'b0,
                  2'b01, 1'b1, 12'h004, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, 3);
    tbl[1]  = mkv(2'b11, 2'b00, 12'hFE0, 12'hFE0, 32'h1111_1111, 32'h2222_2222, 4'hF, 4'hF, 0, 32'h19, 1'b0,
                  2'b10, 1'b0, 12'hFE0, 32'h0, 4'h0, 32'h19, 1'b0, 3);
    tbl[2]  = mkv(2'b11, 2'b00, 12'hFE0, 12'hFE0, 32'h1111_1111, 32'h2222_2222, 4'hF, 4'hF, 0, 32'h19, 1'b0,
                  2'b01, 1'b0, 12'hFE0, 32'h0, 4'h0, 32'h19, 1'b0, 3);
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[2];
    tbl[5]  = mkv(2'b01, 2'b01, 12'h010, 12'h000, 32'hCAFE_0001, 32'h0, 4'h3, 4'h0, 0, 32'h0, 1'b1,
                  2'b01, 1'b1, 12'h010, 32'hCAFE_0001, 4'h3, 32'h0, 1'b1, 3);
    tbl[6]  = mkv(2'b10, 2'b00, 12'h000, 12'h020, 32'h0, 32'hFFFF_FFFF, 4'h0, 4'hF, 0, 32'h1234_5678, 1'b0,
                  2'b10, 1'b0, 12'h020, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3);
    tbl[7]  = mkv(2'b11, 2'b10, 12'h030, 12'h040, 32'h0, 32'h77, 4'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0,
                  2'b01, 1'b0, 12'h030, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 3);
    tbl[8]  = mkv(2'b10, 2'b00, 12'h000, 12'h008, 32'h0, 32'h0, 4'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0,
                  2'b10, 1'b0, 12'h008, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 6);
    tbl[9]  = mkv(2'b01, 2'b00, 12'h100, 12'h000, 32'h0, 32'h0, 4'hF, 4'h0, 100, 32'h5555, 1'b0,
                  2'b01, 1'b0, 12'h100, 32'h0, 4'h0, 32'h0, 1'b1, 18);
    tbl[10] = mkv(2'b11, 2'b11, 12'h0AA, 12'h3FC, 32'h1, 32'h8765_4321, 4'hF, 4'h9, 0, 32'h0, 1'b0,
                  2'b10, 1'b1, 12'h3FC, 32'h8765_4321, 4'h9, 32'h0, 1'b0, 3);
    tbl[11] = mkv(2'b11, 2'b11, 12'h0AA, 12'h3FC, 32'h1, 32'h8765_4321, 4'hF, 4'h9, 1, 32'h0, 1'b0,
                  2'b01, 1'b1, 12'h0AA, 32'h1, 4'hF, 32'h0, 1'b0, 4);

    bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_strb = '0;
    bus.prdata = '0; bus.pslverr = 1'b0;

    // Reset state
    step();
    step();
    chk("reset.psel_penable_pwrite", {bus.psel, bus.penable, bus.pwrite}, 3'b000);
    chk("reset.paddr", bus.paddr, 12'h0);
    chk("reset.pwdata_pstrb", {bus.pwdata, bus.pstrb}, '0);
    chk("reset.done_rsp", {bus.done, bus.rsp_err, bus.rsp_rdata}, '0);
    rst = 1'b0;
    step();
    chk("idle.no_req_psel", bus.psel, 1'b0);

    foreach (tbl[i]) run_xfer($sformatf("tbl%0d", i), tbl[i]);
    bus.req = 2'b00;

    // Asynchronous reset in the middle of ACCESS drops the transfer
    v = tbl[1];
    v.wt = 50;
    apply(v);
    step();
    step();
    chk("arst.pre_penable", bus.penable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst.immediate_psel_penable", {bus.psel, bus.penable}, 2'b00);
    chk("arst.immediate_done", bus.done, 2'b00);
    chk("arst.immediate_paddr", bus.paddr, 12'h0);
    @(posedge pclk);
    #1 rst = 1'b0;
    chk("arst.no_done", bus.done, 2'b00);
    v = tbl[2];
    run_xfer("arst.first_gnt", v);
    bus.req = 2'b00;

    // Random transfers against the transaction-level model
    rst = 1'b1;
    step();
    rst = 1'b0;
    last = 1;
    for (int n = 0; n < 40; n++) begin
      v.req  = 2'($urandom_range(0, 3));
      v.wr   = 2'($urandom);
      v.a0   = AW'($urandom); v.a1 = AW'($urandom);
      v.d0   = $urandom;      v.d1 = $urandom;
      v.s0   = SW'($urandom); v.s1 = SW'($urandom);
      v.wt   = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      v.rd   = $urandom;
      v.er   = 1'($urandom);
      v.drop = 1'($urandom);
      if (v.req == 2'b00) begin
        apply(v);
        step();
        chk($sformatf("rnd%0d.idle_psel", n), bus.psel, 1'b0);
        continue;
      end
      g = (v.req == 2'b11) ? 1 - last : ((v.req == 2'b10) ? 1 : 0);
      timed    = (v.wt >= TIMEOUT);
      v.e_done = 2'(1 << g);
      v.e_wr   = v.wr[g];
      v.e_addr = (g == 1) ? v.a1 : v.a0;
      v.e_wd   = v.e_wr ? ((g == 1) ? v.d1 : v.d0) : '0;
      v.e_strb = v.e_wr ? ((g == 1) ? v.s1 : v.s0) : '0;
      v.e_rd   = (timed || v.e_wr) ? '0 : v.rd;
      v.e_er   = timed ? 1'b1 : v.er;
      v.e_lat  = 3 + (timed ? TIMEOUT - 1 : v.wt);
      last = g;
      run_xfer($sformatf("rnd%0d", n), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-requester APB4 master front-end that shares one register slave (addr/data/strobe interface, PID/CID space) between two on-chip requesters.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases toward the slave.
- Returns read data and error status, and bounds slave wait states with a timeout.
- Sits between the requesters (e.g. debug port, CPU config path) and the APB bridge/slave.

Parameters:
ADDR_WIDTH, 12, APB address width
DATA_WIDTH, 32, APB data width; strobe width is DATA_WIDTH/8
TIMEOUT, 16, max ACCESS cycles without pready before abort; legal range 2..255

Ports:
pclk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  2  per-requester transfer request, bit i = requester i
req_write  in  2  1=write, 0=read, per requester
req_addr  in  2*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  2*DATA_WIDTH  requester i write data
req_strb  in  2*DATA_WIDTH/8  requester i byte strobes
done  out  2  one-cycle completion pulse to the serviced requester
rsp_rdata  out  DATA_WIDTH  read data, valid while done is high
rsp_err  out  1  error status, valid while done is high
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB byte strobes
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, done=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0, last_gnt=1 (requester 0 wins first contest).
- Reset is asynchronous: any state returns to IDLE immediately. An in-flight transfer is dropped with no done pulse.
- All outputs are registered. FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If both are set, grant requester ~last_gnt.
  - On grant: latch the granted requester's write/addr/wdata/strb into pwrite/paddr/pwdata/pstrb; set psel=1, penable=0; go to SETUP.
  - For reads, pstrb is forced to 0 and pwdata to 0.
- SETUP: exactly one cycle. Set penable=1, clear the wait counter, go to ACCESS.
- ACCESS:
  - pready=1: set psel=0, penable=0; done[g]=1; rsp_err=pslverr; rsp_rdata=prdata for a read, 0 for a write; last_gnt=g; go to RESP.
  - pready=0: increment the wait counter. When the counter reaches TIMEOUT-1 with pready still low, abort: same exit as above but rsp_err=1 and rsp_rdata=0.
- RESP: exactly one cycle. done clears, rsp_rdata and rsp_err clear to 0. Arbitration is blocked; req is ignored. Go to IDLE.
- The RESP cycle guarantees a requester can drop req after seeing done without being double-serviced.
- Command fields are sampled only at grant; later changes or req deassertion do not affect the in-flight transfer.
- A req deasserted before it is granted is never serviced.
- Latency with a zero-wait slave:
  - Cycle t0: IDLE samples req.
  - t1: SETUP (psel=1).
  - t2: ACCESS (penable=1, pready sampled).
  - t3: RESP (done=1).
  - t4: IDLE again.
  - Throughput is one transfer per 4 cycles; each slave wait state adds one cycle.
- paddr, pwrite, pwdata and pstrb hold stable from SETUP through the ACCESS exit cycle. They keep their last value when idle.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1…
- done is never asserted on both bits at once.

Test Plan:
1. Reset, then req=01 write addr=0x004 wdata=0xA5A5_1234 strb=0xF, pready tied 1 -> psel at t1, penable at t2, pwrite=1 paddr=0x004 pstrb=0xF, done=01 at t3 with rsp_err=0, psel=0 at t3.
2. req=11 held continuously, both reading addr 0xFE0, pready=1, prdata=0x19 -> grant order 0,1,0,1; done pulses every 4 cycles, alternating bits; rsp_rdata=0x19; pstrb=0 on every read.
3. Requester 1 reads 0x008 with pready low for 3 ACCESS cycles, prdata=0xDEAD_BEEF when pready rises -> done=10 exactly 3 cycles later than zero-wait; paddr stable throughout; rsp_rdata=0xDEAD_BEEF.
4. Requester 0 writes addr 0x010, slave returns pready=1, pslverr=1 -> done=01, rsp_err=1; the next transfer reports rsp_err=0.
5. pready held 0 with TIMEOUT=16 -> done asserts 16 cycles after penable rises, rsp_err=1, rsp_rdata=0; psel and penable low in the same cycle; the FSM then accepts the next req.
6. Assert rst for 1 cycle during ACCESS -> psel, penable, done and all outputs go to 0 immediately; no done pulse; after release with req=11, requester 0 is granted first.
